ef_uart_tx_sched: RTL and testbench



---
 rtl/ef_uart_sched_pkg.sv | 24 ++
 rtl/ef_uart_rr_arbiter.sv | 36 +++
 rtl/ef_uart_tx_sched.sv | 169 ++++++++++++++++
 tb/tb_ef_uart_tx_sched.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_uart_sched_pkg.sv
// Shared definitions for the EF_UART transmit scheduler.
// Holds the UART register offsets, the RIS TX-full bit index and the
// scheduler FSM state encoding.
package ef_uart_sched_pkg;

  localparam logic [31:0] OFF_DATA     = 32'h0000_0000;
  localparam logic [31:0] OFF_PRESCALE = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL     = 32'h0000_0100;
  localparam logic [31:0] OFF_RIS      = 32'h0000_0200;
  localparam logic [31:0] OFF_ICR      = 32'h0000_020C;

  localparam int TXFULL_BIT = 0;

  typedef enum logic [2:0] {
    INIT_PS,
    INIT_CTRL,
    IDLE,
    RD_RIS,
    CLR_ICR,
    GAP,
    WR_DATA
  } state_t;

endpackage

// File: rtl/ef_uart_rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   valid     - pending request bits
//   ptr       - index with highest priority this round
//   grant_oh  - one-hot grant (zero when nothing is pending)
//   grant_idx - binary index of the grant
//   found     - at least one request pending
module ef_uart_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [IW-1:0]    grant_idx,
  output logic             found
);

  logic [IW-1:0] idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!found && valid[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/ef_uart_tx_sched.sv
// Round-robin scheduler sharing one EF_UART transmit path between
// N_REQ byte requesters. Acts as the only APB master of the UART:
// initialises PRESCALE/CTRL, then per byte polls RIS, clears a sticky
// TX-full through ICR (with a retry gap) and writes the granted byte.
// Ports:
//   PCLK, PRESET         - clock, synchronous active-high reset
//   req_valid/req_data   - requester handshake and bytes (byte i at [8i+7:8i])
//   req_ready            - one-cycle accept pulse per requester
//   init_done            - init writes complete, sticky until reset
//   PSEL..PREADY         - APB master interface to the UART
//
// state     | meaning
// INIT_PS   | APB write of PRESCALE
// INIT_CTRL | APB write of CTRL_VAL
// IDLE      | wait for a request, latch grant and byte
// RD_RIS    | APB read of RIS, branch on TX-full
// CLR_ICR   | APB write 1 to ICR to clear TX-full
// GAP       | RETRY_GAP idle cycles before re-reading RIS
// WR_DATA   | APB write of latched byte to DATA
module ef_uart_tx_sched
  import ef_uart_sched_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] PRESCALE  = 16'd0,
  parameter logic [31:0] CTRL_VAL  = 32'h7,
  parameter int          RETRY_GAP = 2
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               init_done,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PADDR,
  output logic [31:0]        PWDATA,
  input  logic [31:0]        PRDATA,
  input  logic               PREADY
);

  localparam int          IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  GAP_LOAD = 8'(RETRY_GAP - 1);

  state_t           state_q, state_d;
  logic             access_q, access_d;
  logic             run_q;
  logic             init_q;
  logic [IW-1:0]    ptr_q, grant_q;
  logic [N_REQ-1:0] grant_oh_q;
  logic [7:0]       byte_q;
  logic [N_REQ-1:0] ready_q;
  logic [7:0]       gap_q;

  logic [N_REQ-1:0] valid_m;
  logic [N_REQ-1:0] arb_oh;
  logic [IW-1:0]    arb_idx;
  logic             arb_found;

  logic             is_xfer, is_read, xfer_done;
  logic [31:0]      offset, wdata;
  logic             unused_prdata;

  assign unused_prdata = ^PRDATA[31:1];

  // A requester still holds req_valid during its req_ready cycle; masking
  // it keeps the already-accepted byte from being granted a second time.
  assign valid_m = req_valid & ~ready_q;

  ef_uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .valid     (valid_m),
    .ptr       (ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .found     (arb_found)
  );

  always_comb begin
    state_d  = state_q;
    access_d = access_q;
    is_xfer  = 1'b0;
    is_read  = 1'b0;
    offset   = '0;
    wdata    = '0;

    case (state_q)
      INIT_PS:   begin is_xfer = 1'b1; offset = OFF_PRESCALE; wdata = {16'h0, PRESCALE}; end
      INIT_CTRL: begin is_xfer = 1'b1; offset = OFF_CTRL;     wdata = CTRL_VAL; end
      RD_RIS:    begin is_xfer = 1'b1; is_read = 1'b1; offset = OFF_RIS; end
      CLR_ICR:   begin is_xfer = 1'b1; offset = OFF_ICR;      wdata = 32'h1; end
      WR_DATA:   begin is_xfer = 1'b1; offset = OFF_DATA;     wdata = {24'h0, byte_q}; end
      default:   ;
    endcase

    xfer_done = run_q && is_xfer && access_q && PREADY;

    // run_q holds everything off during reset and for its release edge, so
    // the PRESCALE SETUP appears in the first cycle after reset release.
    if (run_q) begin
      if (is_xfer) begin
        if (!access_q)   access_d = 1'b1;
        else if (PREADY) access_d = 1'b0;
      end
      case (state_q)
        INIT_PS:   if (xfer_done) state_d = INIT_CTRL;
        INIT_CTRL: if (xfer_done) state_d = IDLE;
        IDLE:      if (arb_found) state_d = RD_RIS;
        RD_RIS:    if (xfer_done) state_d = PRDATA[TXFULL_BIT] ? CLR_ICR : WR_DATA;
        CLR_ICR:   if (xfer_done) state_d = GAP;
        GAP:       if (gap_q == 8'd0) state_d = RD_RIS;
        WR_DATA:   if (xfer_done) state_d = IDLE;
        default:   state_d = INIT_PS;
      endcase
    end

    PSEL    = run_q && is_xfer;
    PENABLE = PSEL && access_q;
    PWRITE  = PSEL && !is_read;
    PADDR   = PSEL ? (BASE_ADDR + offset) : '0;
    PWDATA  = PWRITE ? wdata : '0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= INIT_PS;
      access_q   <= 1'b0;
      run_q      <= 1'b0;
      init_q     <= 1'b0;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      byte_q     <= '0;
      ready_q    <= '0;
      gap_q      <= '0;
    end else begin
      run_q    <= 1'b1;
      state_q  <= state_d;
      access_q <= access_d;
      ready_q  <= '0;

      if (state_q == IDLE && arb_found) begin
        grant_q    <= arb_idx;
        grant_oh_q <= arb_oh;
        byte_q     <= req_data[{arb_idx, 3'b000} +: 8];
      end

      if (xfer_done && state_q == WR_DATA) begin
        ready_q <= grant_oh_q;
        ptr_q   <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
      end

      if (xfer_done && state_q == INIT_CTRL) init_q <= 1'b1;

      if (xfer_done && state_q == CLR_ICR)
        gap_q <= GAP_LOAD;
      else if (state_q == GAP && gap_q != 8'd0)
        gap_q <= gap_q - 8'd1;
    end
  end

  assign req_ready = ready_q;
  assign init_done = init_q;

endmodule

// File: tb/tb_ef_uart_tx_sched.sv
// Directed bench for ef_uart_tx_sched: a small APB slave answers RIS reads
// (TX-full for a programmable number of reads), every completed APB
// transfer and req_ready pulse is logged, and each test task compares the
// log and sampled outputs against hand-derived values.
module tb_ef_uart_tx_sched;

  localparam int N = 4;

  logic           PCLK = 1'b0;
  logic           PRESET;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           init_done;
  logic           PSEL, PENABLE, PWRITE;
  logic [31:0]    PADDR, PWDATA, PRDATA;
  logic           PREADY;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_xfer = 0;
  int n_rdy = 0;
  int ris_cnt = 0;
  int full_until = 0;

  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  logic        log_wr   [256];
  int          log_cyc  [256];
  logic [N-1:0] rdy_val [256];
  int           rdy_cyc [256];

  always #5 PCLK = ~PCLK;

  // RIS reads report TX-full while ris_cnt < full_until; the clear value
  // carries ones in unrelated bits so only bit 0 may steer the FSM.
  assign PRDATA = (PSEL && !PWRITE && PADDR == 32'h200) ?
                  ((ris_cnt < full_until) ? 32'h0000_0001 : 32'hFFFF_FFFE) : 32'h0;

  ef_uart_tx_sched #(
    .N_REQ     (N),
    .BASE_ADDR (32'h0),
    .PRESCALE  (16'd26),
    .CTRL_VAL  (32'h7),
    .RETRY_GAP (2)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  always @(posedge PCLK) begin
    cyc = cyc + 1;
    if (PSEL && PENABLE && PREADY && n_xfer < 256) begin
      log_addr[n_xfer] = PADDR;
      log_data[n_xfer] = PWDATA;
      log_wr[n_xfer]   = PWRITE;
      log_cyc[n_xfer]  = cyc;
      n_xfer = n_xfer + 1;
      if (!PWRITE && PADDR == 32'h200) ris_cnt <= ris_cnt + 1;
    end
    if (req_ready != '0 && n_rdy < 256) begin
      rdy_val[n_rdy] = req_ready;
      rdy_cyc[n_rdy] = cyc;
      n_rdy = n_rdy + 1;
    end
  end

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset;
    PRESET = 1'b1;
    req_valid = '0;
    PREADY = 1'b1;
    tick();
    tick();
    PRESET = 1'b0;
    for (int i = 0; i < 20 && !init_done; i++) tick();
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_timeout: init_done=%b required 1", init_done);
    end
  endtask

  task automatic test_reset;
    int base;
    PRESET = 1'b1;
    req_valid = '0;
    req_data = '0;
    PREADY = 1'b1;
    tick_n(3);
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: psel/penable/pwrite=%b required 000", {PSEL, PENABLE, PWRITE});
    end
    checks++;
    if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: paddr=%h pwdata=%h required 0/0", PADDR, PWDATA);
    end
    checks++;
    if (req_ready !== 4'b0000 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: req_ready=%b init_done=%b required 0000/0", req_ready, init_done);
    end

    base = n_xfer;
    PRESET = 1'b0;
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h4 || PWDATA !== 32'd26) begin
      errors++;
      $display("FAIL init_ps_setup: ctl=%b addr=%h data=%h required 101/4/1a", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11 || PADDR !== 32'h4) begin
      errors++;
      $display("FAIL init_ps_access: sel/en=%b addr=%h required 11/4", {PSEL, PENABLE}, PADDR);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h100 || PWDATA !== 32'h7) begin
      errors++;
      $display("FAIL init_ctrl_setup: ctl=%b addr=%h data=%h required 101/100/7", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    checks++;
    if (PENABLE !== 1'b1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL init_ctrl_access: penable=%b init_done=%b required 1/0", PENABLE, init_done);
    end
    tick();
    checks++;
    if (init_done !== 1'b1 || PSEL !== 1'b0) begin
      errors++;
      $display("FAIL init_done_c5: init_done=%b psel=%b required 1/0", init_done, PSEL);
    end
    tick_n(5);
    checks++;
    if (n_xfer - base !== 2) begin
      errors++;
      $display("FAIL init_count: transfers=%0d required 2", n_xfer - base);
    end else begin
      checks++;
      if (log_addr[base] !== 32'h4 || log_data[base] !== 32'd26 || log_wr[base] !== 1'b1 ||
          log_addr[base+1] !== 32'h100 || log_data[base+1] !== 32'h7 || log_wr[base+1] !== 1'b1) begin
        errors++;
        $display("FAIL init_log: %h<-%h, %h<-%h required 4<-1a, 100<-7",
                 log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]);
      end
    end
  endtask

  task automatic test_single_req;
    int base, rbase;
    base = n_xfer;
    rbase = n_rdy;
    req_data = 32'h005A_0000;
    req_valid = 4'b0100;
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h200) begin
      errors++;
      $display("FAIL single_ris_setup: ctl=%b addr=%h required 100/200", {PSEL, PENABLE, PWRITE}, PADDR);
    end
    tick();
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h0 || PWDATA !== 32'h5A) begin
      errors++;
      $display("FAIL single_data_setup: ctl=%b addr=%h data=%h required 101/0/5a", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_early_ready: req_ready=%b required 0000", req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: req_ready=%b required 0100", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (req_ready !== 4'b0000 || PSEL !== 1'b0) begin
      errors++;
      $display("FAIL single_after: req_ready=%b psel=%b required 0000/0", req_ready, PSEL);
    end
    tick_n(4);
    checks++;
    if (n_xfer - base !== 2 || n_rdy - rbase !== 1) begin
      errors++;
      $display("FAIL single_counts: transfers=%0d pulses=%0d required 2/1", n_xfer - base, n_rdy - rbase);
    end
  endtask

  task automatic test_round_robin;
    int base, rbase;
    logic [7:0]   exp_d [5];
    logic [N-1:0] exp_r [5];
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    base = n_xfer;
    rbase = n_rdy;
    req_data = 32'h1312_1110;
    req_valid = 4'b1111;
    for (int i = 0; i < 60 && (n_rdy - rbase) < 5; i++) tick();
    req_valid = '0;
    checks++;
    if (n_rdy - rbase < 5) begin
      errors++;
      $display("FAIL rr_timeout: pulses=%0d required 5", n_rdy - rbase);
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (log_addr[base+2*k] !== 32'h200 || log_addr[base+2*k+1] !== 32'h0 ||
            log_data[base+2*k+1] !== {24'h0, exp_d[k]}) begin
          errors++;
          $display("FAIL rr_write%0d: ris=%h data_addr=%h data=%h required 200/0/%h",
                   k, log_addr[base+2*k], log_addr[base+2*k+1], log_data[base+2*k+1], exp_d[k]);
        end
        checks++;
        if (rdy_val[rbase+k] !== exp_r[k]) begin
          errors++;
          $display("FAIL rr_ready%0d: req_ready=%b required %b", k, rdy_val[rbase+k], exp_r[k]);
        end
      end
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (rdy_cyc[rbase+k] - rdy_cyc[rbase+k-1] !== 5) begin
          errors++;
          $display("FAIL rr_spacing%0d: cycles=%0d required 5", k, rdy_cyc[rbase+k] - rdy_cyc[rbase+k-1]);
        end
      end
    end
    tick_n(8);
  endtask

  task automatic test_full_retry;
    int base, rbase;
    logic [31:0] exp_a [6];
    logic        exp_w [6];
    exp_a = '{32'h200, 32'h20C, 32'h200, 32'h20C, 32'h200, 32'h0};
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    base = n_xfer;
    rbase = n_rdy;
    full_until = ris_cnt + 2;
    req_data = 32'h0000_00C3;
    req_valid = 4'b0001;
    for (int i = 0; i < 60 && n_rdy == rbase; i++) begin
      tick();
      if (req_ready != '0) req_valid = '0;
    end
    req_valid = '0;
    tick_n(4);
    checks++;
    if (n_xfer - base !== 6) begin
      errors++;
      $display("FAIL full_count: transfers=%0d required 6", n_xfer - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (log_addr[base+k] !== exp_a[k] || log_wr[base+k] !== exp_w[k]) begin
          errors++;
          $display("FAIL full_seq%0d: addr=%h write=%b required %h/%b",
                   k, log_addr[base+k], log_wr[base+k], exp_a[k], exp_w[k]);
        end
      end
      checks++;
      if (log_data[base+1] !== 32'h1 || log_data[base+3] !== 32'h1 || log_data[base+5] !== 32'hC3) begin
        errors++;
        $display("FAIL full_wdata: icr=%h icr=%h data=%h required 1/1/c3",
                 log_data[base+1], log_data[base+3], log_data[base+5]);
      end
      checks++;
      if (log_cyc[base+2] - log_cyc[base+1] !== 4) begin
        errors++;
        $display("FAIL full_gap: icr_to_ris=%0d cycles required 4", log_cyc[base+2] - log_cyc[base+1]);
      end
    end
    checks++;
    if (n_rdy - rbase !== 1 || rdy_val[rbase] !== 4'b0001) begin
      errors++;
      $display("FAIL full_ready: pulses=%0d value=%b required 1/0001", n_rdy - rbase, rdy_val[rbase]);
    end
  endtask

  task automatic test_wait_states;
    int rbase;
    rbase = n_rdy;
    req_data = 32'h0000_A700;
    req_valid = 4'b0010;
    tick_n(3);
    PREADY = 1'b0;
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h0) begin
      errors++;
      $display("FAIL wait_setup: ctl=%b addr=%h required 101/0", {PSEL, PENABLE, PWRITE}, PADDR);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (PENABLE !== 1'b1 || PWRITE !== 1'b1 || PADDR !== 32'h0 || PWDATA !== 32'hA7 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL wait_access%0d: en=%b wr=%b addr=%h data=%h ready=%b required 1/1/0/a7/0000",
                 i, PENABLE, PWRITE, PADDR, PWDATA, req_ready);
      end
      if (i == 3) PREADY = 1'b1;
    end
    tick();
    checks++;
    if (req_ready !== 4'b0010 || PSEL !== 1'b0) begin
      errors++;
      $display("FAIL wait_ready: req_ready=%b psel=%b required 0010/0", req_ready, PSEL);
    end
    req_valid = '0;
    tick_n(3);
    checks++;
    if (n_rdy - rbase !== 1) begin
      errors++;
      $display("FAIL wait_pulses: pulses=%0d required 1", n_rdy - rbase);
    end
  endtask

  task automatic test_reset_mid;
    int base, rbase;
    base = n_xfer;
    rbase = n_rdy;
    req_data = 32'h3C00_0000;
    req_valid = 4'b1000;
    tick_n(3);
    PREADY = 1'b0;
    tick();
    checks++;
    if (PENABLE !== 1'b1 || PADDR !== 32'h0 || PWDATA !== 32'h3C) begin
      errors++;
      $display("FAIL mid_access: en=%b addr=%h data=%h required 1/0/3c", PENABLE, PADDR, PWDATA);
    end
    PRESET = 1'b1;
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000 || PADDR !== 32'h0 || PWDATA !== 32'h0 ||
        req_ready !== 4'b0000 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ctl=%b addr=%h data=%h ready=%b init=%b required 000/0/0/0000/0",
               {PSEL, PENABLE, PWRITE}, PADDR, PWDATA, req_ready, init_done);
    end
    PRESET = 1'b0;
    PREADY = 1'b1;
    req_valid = '0;
    tick();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h4 || PWDATA !== 32'd26) begin
      errors++;
      $display("FAIL mid_reinit: ctl=%b addr=%h data=%h required 101/4/1a", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick_n(6);
    checks++;
    if (init_done !== 1'b1 || n_rdy !== rbase) begin
      errors++;
      $display("FAIL mid_after: init_done=%b pulses=%0d required 1/0", init_done, n_rdy - rbase);
    end
    checks++;
    if (n_xfer - base !== 3 || log_addr[base+1] !== 32'h4 || log_addr[base+2] !== 32'h100) begin
      errors++;
      $display("FAIL mid_log: transfers=%0d addr1=%h addr2=%h required 3/4/100",
               n_xfer - base, log_addr[base+1], log_addr[base+2]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_full_retry();
    test_wait_states();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
